// File: rtl/spike_binner_pkg.sv
// Shared types and constants for the spike binning front end.
// Rate values are carried as zero-extended SPIKE_RATE_BIT-wide words.
package spike_binner_pkg;

    localparam int unsigned SPIKE_RATE_BIT = 3;
    localparam int unsigned RATE_MAX_DEF   = 4;

    typedef logic [SPIKE_RATE_BIT-1:0] rate_t;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } drain_state_t;

    // Adds one when requested, but never goes past the saturation value.
    function automatic rate_t rate_sat_inc(input rate_t v, input logic inc, input rate_t max_v);
        if (inc && (v < max_v)) begin
            return rate_t'(v + 1'b1);
        end
        return v;
    endfunction

endpackage

// File: rtl/spike_binner_if.sv
// Valid/ready stream of binned per-channel rates towards the mapper/encoder.
interface spike_binner_if #(
    parameter int unsigned N_CH = 4
);
    import spike_binner_pkg::*;

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    rate_t           rate_out;
    logic [CH_W-1:0] ch_out;
    logic            rate_valid;
    logic            rate_ready;

    modport master (output rate_out, output ch_out, output rate_valid, input rate_ready);
    modport slave  (input rate_out, input ch_out, input rate_valid, output rate_ready);

endinterface

// File: rtl/spike_binner_rate_histogram.sv
// Histogram of emitted rates: one saturating counter per rate value,
// synchronous clear and a combinational mode (argmax, lowest rate wins ties).
module rate_histogram
    import spike_binner_pkg::*;
#(
    parameter int unsigned NBINS  = RATE_MAX_DEF + 1,
    parameter int unsigned HIST_W = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  rate_t idx,
    input  logic  clr,
    output rate_t mode
);

    logic [HIST_W-1:0] hist [NBINS];
    logic [HIST_W-1:0] best_cnt;
    rate_t             best_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                hist[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                hist[i] <= '0;
            end
        end else if (inc) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                if ((idx == rate_t'(i)) && (hist[i] != '1)) begin
                    hist[i] <= hist[i] + 1'b1;
                end
            end
        end
    end

    // Strict greater-than keeps the earliest (lowest) rate on ties.
    always_comb begin
        best_cnt = hist[0];
        best_idx = '0;
        for (int unsigned i = 1; i < NBINS; i++) begin
            if (hist[i] > best_cnt) begin
                best_cnt = hist[i];
                best_idx = rate_t'(i);
            end
        end
        mode = best_idx;
    end

endmodule

// File: rtl/spike_binner.sv
// Bins per-channel spike pulses into saturating rates, drains each bin over a
// valid/ready stream and publishes the most frequent rate every HIST_BINS bins.
module spike_binner
    import spike_binner_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned BIN_CYCLES = 1000,
    parameter int unsigned RATE_MAX   = RATE_MAX_DEF,
    parameter int unsigned HIST_BINS  = 256,
    parameter int unsigned HIST_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_CH-1:0]       spike_in,
    spike_binner_if.master        rate_if,
    output rate_t                 max_rate,
    output logic                  overrun
);

    localparam int unsigned TMR_W  = (BIN_CYCLES > 1) ? $clog2(BIN_CYCLES) : 1;
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BCNT_W = $clog2(HIST_BINS + 1);
    localparam rate_t       RMAX   = rate_t'(RATE_MAX);

    drain_state_t      state, state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [CH_W-1:0]   ch;
    logic [BCNT_W-1:0] bin_cnt;
    logic              done_q;
    rate_t             cnt    [N_CH];
    rate_t             shadow [N_CH];
    rate_t             rate_cur;
    rate_t             hist_mode;

    logic bin_end, load, hs, last_ch, final_hs, publish, valid;

    assign bin_end  = enable && (timer == TMR_W'(BIN_CYCLES - 1));
    assign load     = bin_end && (state == ST_IDLE);
    assign valid    = (state == ST_DRAIN);
    assign hs       = valid && rate_if.rate_ready;
    assign last_ch  = (ch == CH_W'(N_CH - 1));
    assign final_hs = hs && last_ch;
    assign publish  = done_q && (bin_cnt == BCNT_W'(HIST_BINS));
    assign rate_cur = valid ? shadow[ch] : '0;

    assign rate_if.rate_valid = valid;
    assign rate_if.rate_out   = rate_cur;
    assign rate_if.ch_out     = ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (load)     state_nxt = ST_DRAIN;
            ST_DRAIN: if (final_hs) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // A spike on the bin-end cycle belongs to the ending bin, so the snapshot
    // takes the incremented value while the live counter restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else if (enable) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (bin_end) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= rate_sat_inc(cnt[i], spike_in[i], RMAX);
                end
                if (load) begin
                    shadow[i] <= rate_sat_inc(cnt[i], spike_in[i], RMAX);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            ch       <= '0;
            overrun  <= 1'b0;
            bin_cnt  <= '0;
            done_q   <= 1'b0;
            max_rate <= '0;
        end else begin
            if (enable) begin
                timer <= bin_end ? '0 : timer + 1'b1;
            end
            if (load) begin
                ch <= '0;
            end else if (hs) begin
                ch <= last_ch ? '0 : ch + 1'b1;
            end
            if (bin_end && (state == ST_DRAIN)) begin
                overrun <= 1'b1;
            end
            // Publishing waits one cycle after the final handshake so the
            // histogram already holds that last rate and the drain is over.
            done_q <= final_hs;
            if (publish) begin
                bin_cnt  <= '0;
                max_rate <= hist_mode;
            end else if (final_hs) begin
                bin_cnt <= bin_cnt + 1'b1;
            end
        end
    end

    rate_histogram #(
        .NBINS  (RATE_MAX + 1),
        .HIST_W (HIST_W)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .inc  (hs),
        .idx  (rate_cur),
        .clr  (publish),
        .mode (hist_mode)
    );

endmodule

// File: tb/tb_spike_binner.sv
// Scoreboard bench for spike_binner: a cycle model of the bin timer and
// counters pushes expected stream items, drained items are popped and compared.
module tb_spike_binner;
    import spike_binner_pkg::*;

    localparam int NCH = 4;
    localparam int BC  = 16;
    localparam int HB  = 2;
    localparam int RM  = 4;

    typedef struct packed {
        logic [1:0] ch;
        rate_t      rate;
    } item_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [NCH-1:0] spike_in = '0;
    rate_t          max_rate;
    logic           overrun;

    spike_binner_if #(.N_CH(NCH)) rif ();

    spike_binner #(
        .N_CH       (NCH),
        .BIN_CYCLES (BC),
        .RATE_MAX   (RM),
        .HIST_BINS  (HB),
        .HIST_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .spike_in (spike_in),
        .rate_if  (rif),
        .max_rate (max_rate),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    item_t exp_q[$];
    int    m_timer;
    int    m_cnt [NCH];
    logic  m_ovr;
    logic  m_binend;

    task automatic model_clear();
        m_timer = 0;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        m_ovr    = 1'b0;
        m_binend = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle, advance the model, check the stream at the negedge.
    task automatic step(input logic [NCH-1:0] sp, input logic en);
        int    snap [NCH];
        int    nc;
        item_t it;
        spike_in = sp;
        enable   = en;
        m_binend = 1'b0;
        if (en) begin
            m_binend = (m_timer == BC - 1);
            for (int c = 0; c < NCH; c++) begin
                nc = m_cnt[c] + (sp[c] ? 1 : 0);
                if (nc > RM) nc = RM;
                snap[c]  = nc;
                m_cnt[c] = m_binend ? 0 : nc;
            end
            if (m_binend) begin
                if (exp_q.size() == 0) begin
                    for (int c = 0; c < NCH; c++) begin
                        it.ch   = 2'(c);
                        it.rate = rate_t'(snap[c]);
                        exp_q.push_back(it);
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_timer = m_binend ? 0 : m_timer + 1;
        end
        @(negedge clk);
        if (rif.rate_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_unexpected: got ch=%0d rate=%0d, required no valid", rif.ch_out, rif.rate_out);
            end else begin
                it = exp_q[0];
                if ({rif.ch_out, rif.rate_out} !== it) begin
                    bad++;
                    $display("FAIL stream_item: got ch=%0d rate=%0d, required ch=%0d rate=%0d",
                             rif.ch_out, rif.rate_out, it.ch, it.rate);
                end
                if (rif.rate_ready) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1);
    endtask

    // Runs to the next bin end; every channel fires r times starting at timer 8.
    task automatic run_bin(input int r);
        for (int k = 0; k < BC; k++) begin
            step((m_timer >= 8 && m_timer < 8 + r) ? '1 : '0, 1'b1);
            if (m_binend) break;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        spike_in = '0;
        model_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0 || rif.rate_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drained: got pending=%0d valid=%0b, required pending=0 valid=0",
                     name, exp_q.size(), rif.rate_valid);
        end
    endtask

    task automatic check_max(input string name, input rate_t exp_v);
        total++;
        if (max_rate !== exp_v) begin
            bad++;
            $display("FAIL %s: got max_rate=%0d, required %0d", name, max_rate, exp_v);
        end
    endtask

    task automatic test_reset();
        model_clear();
        rif.rate_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({rif.rate_valid, rif.rate_out, rif.ch_out, max_rate, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b rate=%0d ch=%0d max=%0d ovr=%0b, required all 0",
                     rif.rate_valid, rif.rate_out, rif.ch_out, max_rate, overrun);
        end
        rst = 1'b0;
        run_bin(2);
        step('0, 1'b1);
        step('0, 1'b1);
        total++;
        if (rif.ch_out !== 2'd2 || rif.rate_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_ch: got ch=%0d valid=%0b, required ch=2 valid=1", rif.ch_out, rif.rate_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (rif.rate_valid !== 1'b0 || max_rate !== '0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got valid=%0b max=%0d ovr=%0b, required 0 0 0",
                     rif.rate_valid, max_rate, overrun);
        end
        do_reset();
        run_bin(1);
        total++;
        if (rif.rate_valid !== 1'b1 || rif.ch_out !== 2'd0) begin
            bad++;
            $display("FAIL reset_restart: got valid=%0b ch=%0d, required valid=1 ch=0", rif.rate_valid, rif.ch_out);
        end
        idle(6);
        check_drained("reset");
    endtask

    task automatic test_stream();
        logic [NCH-1:0] sp;
        do_reset();
        rif.rate_ready = 1'b1;
        for (int k = 0; k < BC; k++) begin
            sp = '0;
            if (m_timer == 1 || m_timer == 3)  sp[0] = 1'b1;
            if (m_timer >= 2 && m_timer <= 8)  sp[1] = 1'b1;
            if (m_timer == BC - 1)             sp[3] = 1'b1;
            step(sp, 1'b1);
            if (m_binend) break;
        end
        total++;
        if ({rif.rate_valid, rif.ch_out, rif.rate_out} !== {1'b1, 2'd0, 3'd2}) begin
            bad++;
            $display("FAIL stream_first: got valid=%0b ch=%0d rate=%0d, required 1 0 2",
                     rif.rate_valid, rif.ch_out, rif.rate_out);
        end
        for (int k = 1; k < NCH; k++) begin
            step('0, 1'b1);
            total++;
            if (rif.rate_valid !== 1'b1 || rif.ch_out !== 2'(k)) begin
                bad++;
                $display("FAIL stream_consecutive: got valid=%0b ch=%0d, required valid=1 ch=%0d",
                         rif.rate_valid, rif.ch_out, k);
            end
        end
        step('0, 1'b1);
        check_drained("stream");
    endtask

    task automatic test_stall();
        do_reset();
        rif.rate_ready = 1'b1;
        run_bin(3);
        step('0, 1'b1);
        rif.rate_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step('0, 1'b1);
            total++;
            if (rif.ch_out !== 2'd1 || rif.rate_out !== 3'd3 || rif.rate_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: got ch=%0d rate=%0d valid=%0b, required ch=1 rate=3 valid=1",
                         rif.ch_out, rif.rate_out, rif.rate_valid);
            end
        end
        rif.rate_ready = 1'b1;
        idle(6);
        check_drained("stall");
    endtask

    task automatic test_histogram();
        do_reset();
        rif.rate_ready = 1'b1;
        run_bin(3); idle(6);
        check_max("hist_after_bin1", 3'd0);
        run_bin(3); idle(6);
        check_max("hist_after_bin2", 3'd3);
        run_bin(1); idle(6);
        check_max("hist_after_bin3", 3'd3);
        run_bin(1); idle(6);
        check_max("hist_after_bin4", 3'd1);
        check_drained("hist");
    endtask

    task automatic test_tie();
        do_reset();
        rif.rate_ready = 1'b1;
        run_bin(3); idle(6);
        run_bin(3); idle(6);
        check_max("tie_setup", 3'd3);
        run_bin(2); idle(6);
        run_bin(0); idle(6);
        check_max("tie_lowest", 3'd0);
    endtask

    task automatic test_overrun();
        do_reset();
        rif.rate_ready = 1'b1;
        run_bin(1);
        rif.rate_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step((m_timer == 3 || m_timer == 5) ? '1 : '0, 1'b1);
            if (k == 14) begin
                total++;
                if (overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL overrun_early: got %0b, required 0", overrun);
                end
            end
        end
        total++;
        if (overrun !== m_ovr || overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got %0b, required 1", overrun);
        end
        rif.rate_ready = 1'b1;
        for (int k = 0; k < BC; k++) begin
            step((m_timer == 10) ? 4'b0010 : 4'b0000, 1'b1);
            if (m_binend) break;
        end
        idle(6);
        check_drained("overrun");
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %0b, required 1", overrun);
        end
    endtask

    initial begin
        rif.rate_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_histogram();
        test_tie();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
